// File: rtl/lane_gather.sv
// lane_gather: reassembles per-lane beats from the demux stage into one
// full-width word, presented on a valid/ready output until consumed.
module lane_gather #(
  parameter  int NUM_DATA  = 4,
  parameter  int DATA_BW   = 8,
  localparam int SEL_WIDTH = $clog2(NUM_DATA)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_WIDTH-1:0]        in_sel,
  input  logic [DATA_BW*NUM_DATA-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BW*NUM_DATA-1:0] out_data,
  output logic [NUM_DATA-1:0]         filled_mask,
  output logic                        err_dup,
  output logic                        err_range
);

  typedef enum logic {FILL, FULL} state_t;

  state_t              state_q, state_d;
  logic [NUM_DATA-1:0] mask_q, mask_d;
  logic [NUM_DATA-1:0] lane_we;
  logic                sel_ok;
  logic                accept;
  logic                dup_d;
  logic                range_d;

  // Non-power-of-two lane counts leave select codes with no lane behind them.
  assign sel_ok = (int'(in_sel) < NUM_DATA);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    lane_we   = '0;
    dup_d     = 1'b0;
    range_d   = 1'b0;
    in_ready  = (state_q == FILL) && !clear;
    out_valid = (state_q == FULL);
    accept    = in_valid && in_ready;

    if (clear) begin
      state_d = FILL;
      mask_d  = '0;
    end else if (state_q == FULL) begin
      if (out_ready) begin
        state_d = FILL;
        mask_d  = '0;
      end
    end else if (accept) begin
      if (sel_ok) begin
        lane_we[in_sel] = 1'b1;
        dup_d           = mask_q[in_sel];
        mask_d[in_sel]  = 1'b1;
        if (&mask_d) state_d = FULL;
      end else begin
        range_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '0;
      err_dup   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      err_dup   <= dup_d;
      err_range <= range_d;
    end
  end

  assign filled_mask = mask_q;

  // Lane registers are only reset by rst; clear and emit leave stale data behind.
  for (genvar g = 0; g < NUM_DATA; g++) begin : g_lane
    logic [DATA_BW-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (lane_we[g]) begin
        lane_q <= in_data[g*DATA_BW +: DATA_BW];
      end
    end

    assign out_data[g*DATA_BW +: DATA_BW] = lane_q;
  end

endmodule

// File: tb/tb_lane_gather.sv
// Bench for lane_gather: directed scenarios plus random traffic on a 4-lane
// and a 3-lane instance, checked against a word-level reference model.
module tb_lane_gather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, ordy;
  logic        v4, v3;
  logic [1:0]  sel4, sel3;
  logic [31:0] din4;
  logic [23:0] din3;
  logic        ir4, ir3, ov4, ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [3:0]  fm4;
  logic [2:0]  fm3;
  logic        ed4, er4, ed3, er3;

  lane_gather #(.NUM_DATA(4), .DATA_BW(8)) u4 (
    .clk(clk), .rst(rst), .clear(clr), .in_valid(v4), .in_ready(ir4),
    .in_sel(sel4), .in_data(din4), .out_valid(ov4), .out_ready(ordy),
    .out_data(od4), .filled_mask(fm4), .err_dup(ed4), .err_range(er4)
  );

  lane_gather #(.NUM_DATA(3), .DATA_BW(8)) u3 (
    .clk(clk), .rst(rst), .clear(clr), .in_valid(v3), .in_ready(ir3),
    .in_sel(sel3), .in_data(din3), .out_valid(ov3), .out_ready(ordy),
    .out_data(od3), .filled_mask(fm3), .err_dup(ed3), .err_range(er3)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the word under construction, which lanes it has, and
  // whether it is waiting to be taken.
  int         mn;
  bit         m_full;
  bit  [3:0]  m_mask;
  logic [7:0] m_lane [4];
  bit         m_dup, m_rng;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    logic [31:0] w = '0;
    for (int i = 0; i < mn; i++) w = w | (32'(m_lane[i]) << (i * 8));
    return w;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_mask = '0;
    m_dup  = 1'b0;
    m_rng  = 1'b0;
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
  endtask

  // One clock cycle on the active instance: drive at the falling edge, check
  // registered outputs and in_ready, advance the model, wait for next fall.
  task automatic cyc(input bit v, input int sel, input logic [7:0] d,
                     input bit o, input bit c, input bit r);
    logic [31:0] bus;
    bit          rdy;
    bus = $urandom;
    if (sel < mn) bus = (bus & ~(32'hFF << (sel * 8))) | (32'(d) << (sel * 8));
    rst  = r;
    clr  = c;
    ordy = o;
    if (mn == 4) begin
      v4 = v; sel4 = 2'(sel); din4 = bus; v3 = 1'b0;
    end else begin
      v3 = v; sel3 = 2'(sel); din3 = bus[23:0]; v4 = 1'b0;
    end
    #1;
    rdy = !m_full && !c;
    if (mn == 4) begin
      chk("in_ready", 64'(ir4), 64'(rdy));
      chk("out_valid", 64'(ov4), 64'(m_full));
      chk("filled_mask", 64'(fm4), 64'(m_mask));
      chk("err_dup", 64'(ed4), 64'(m_dup));
      chk("err_range", 64'(er4), 64'(m_rng));
      if (m_full) chk("out_data", 64'(od4), 64'(m_word()));
    end else begin
      chk("in_ready3", 64'(ir3), 64'(rdy));
      chk("out_valid3", 64'(ov3), 64'(m_full));
      chk("filled_mask3", 64'(fm3), 64'(m_mask));
      chk("err_dup3", 64'(ed3), 64'(m_dup));
      chk("err_range3", 64'(er3), 64'(m_rng));
      if (m_full) chk("out_data3", 64'(od3), 64'(m_word()));
    end
    m_dup = 1'b0;
    m_rng = 1'b0;
    if (r) begin
      model_reset();
    end else if (c) begin
      m_mask = '0;
      m_full = 1'b0;
    end else if (m_full) begin
      if (o) begin
        m_full = 1'b0;
        m_mask = '0;
      end
    end else if (v) begin
      if (sel < mn) begin
        m_dup             = m_mask[2'(sel)];
        m_mask[2'(sel)]   = 1'b1;
        m_lane[2'(sel)]   = d;
        m_full            = ($countones(m_mask) == mn);
      end else begin
        m_rng = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ordy = 1'b0;
    v4 = 1'b0; v3 = 1'b0; sel4 = '0; sel3 = '0; din4 = '0; din3 = '0;
    mn = 4;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(ov4), 64'(0));
    chk("rst_mask", 64'(fm4), 64'(0));
    chk("rst_out_data", 64'(od4), 64'(0));
    chk("rst_err_dup", 64'(ed4), 64'(0));
    chk("rst_err_range", 64'(er4), 64'(0));
    chk("rst_in_ready", 64'(ir4), 64'(1));
    chk("rst_out_data3", 64'(od3), 64'(0));

    // In-order fill
    for (int i = 0; i < 4; i++) cyc(1'b1, i, 8'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b0);
    chk("inorder_valid", 64'(ov4), 64'(1));
    chk("inorder_word", 64'(od4), 64'h44332211);
    cyc(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("inorder_ready_next", 64'(ir4), 64'(1));

    // Out-of-order fill with backpressure
    cyc(1'b1, 2, 8'hA2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 8'hA0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3, 8'hA3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 8'hA1, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      cyc(1'b1, 0, 8'hEE, 1'b0, 1'b0, 1'b0);
      chk("bp_word", 64'(od4), 64'hA3A2A1A0);
      chk("bp_valid", 64'(ov4), 64'(1));
    end
    cyc(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_emitted", 64'(ov4), 64'(0));

    // Duplicate lane
    cyc(1'b1, 1, 8'h05, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 8'h06, 1'b0, 1'b0, 1'b0);
    chk("dup_pulse", 64'(ed4), 64'(1));
    cyc(1'b1, 0, 8'h10, 1'b0, 1'b0, 1'b0);
    chk("dup_once", 64'(ed4), 64'(0));
    cyc(1'b1, 2, 8'h12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3, 8'h13, 1'b0, 1'b0, 1'b0);
    chk("dup_lane1", 64'(od4[15:8]), 64'h06);
    cyc(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Mid-fill clear
    cyc(1'b1, 0, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 8'h78, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2, 8'h79, 1'b0, 1'b1, 1'b0);
    chk("clear_mask", 64'(fm4), 64'(0));
    for (int i = 0; i < 4; i++) cyc(1'b1, i, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("clear_word", 64'(od4), 64'h04030201);

    // Reset while a word is pending
    cyc(1'b1, 0, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("rstfull_valid", 64'(ov4), 64'(0));
    chk("rstfull_mask", 64'(fm4), 64'(0));
    chk("rstfull_data", 64'(od4), 64'(0));
    chk("rstfull_ready", 64'(ir4), 64'(1));

    repeat (400)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 63) == 0);

    // Three-lane instance: has been idle in FILL with empty mask since reset
    mn = 3;
    model_reset();
    cyc(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 0, 8'hB0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("range_pulse", 64'(er3), 64'(1));
    chk("range_mask", 64'(fm3), 64'(3'b001));
    cyc(1'b1, 1, 8'hB1, 1'b0, 1'b0, 1'b0);
    chk("range_not_done", 64'(ov3), 64'(0));
    chk("range_pulse_gone", 64'(er3), 64'(0));
    cyc(1'b1, 2, 8'hB2, 1'b0, 1'b0, 1'b0);
    chk("range_valid", 64'(ov3), 64'(1));
    chk("range_word", 64'(od3), 64'hB2B1B0);
    cyc(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);

    repeat (300)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 63) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_gather.md
# lane_gather

Collects the per-lane outputs of the common demux stage back into a full-width word. Each accepted beat writes one lane, selected by the same select value that steered the demux. Once every lane holds data, the assembled word is presented on a valid/ready output and held until it is consumed. It sits directly downstream of the demux in the RSFQ common library and is used wherever sequentially distributed lane data must be re-presented as one parallel word.

## Interface
- NUM_DATA, 4, number of lanes (≥2; need not be a power of two)
- DATA_BW, 8, bits per lane
- SEL_WIDTH, `log2(NUM_DATA)` (from define.v), select width; derived, not overridden
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous discard of partial contents
- in_valid  input  1  beat offered
- in_ready  output  1  beat can be accepted
- in_sel  input  SEL_WIDTH  lane index of this beat
- in_data  input  DATA_BW*NUM_DATA  demux output bus; only slice in_sel is used
- out_valid  output  1  assembled word available
- out_ready  input  1  consumer takes the word
- out_data  output  DATA_BW*NUM_DATA  assembled word; lane i at [i*DATA_BW +: DATA_BW]
- filled_mask  output  NUM_DATA  bit i set when lane i has been written since the last emit or clear
- err_dup  output  1  one-cycle pulse: an accepted beat rewrote an already-filled lane
- err_range  output  1  one-cycle pulse: an accepted beat carried in_sel ≥ NUM_DATA

## Operation
- Registered state: lane registers (NUM_DATA×DATA_BW), filled_mask, and a two-state FSM (FILL, FULL).
- Accept condition: in_valid && in_ready.
- in_ready = (state == FILL) && !clear. It is a combinational decode of state and clear.
- FILL, accepted beat, in_sel < NUM_DATA:
  - lane[in_sel] ← in_data[in_sel*DATA_BW +: DATA_BW]
  - filled_mask[in_sel] ← 1
  - If that bit was already 1, the lane is overwritten with the new value and err_dup pulses.
- FILL, accepted beat, in_sel ≥ NUM_DATA: the beat is consumed and dropped, nothing is written, and err_range pulses.
- FILL→FULL: on the edge where filled_mask becomes all-ones.
- FULL: out_valid = 1 and out_data = lane registers. The lanes are stable while out_valid is high.
- FULL→FILL: on out_valid && out_ready. filled_mask clears on the same edge. Lane registers keep their stale values, which are not observable because out_valid = 0.
- clear, in either state: filled_mask ← 0, state ← FILL, err flags ← 0. Lane registers are untouched. clear in FULL discards the pending word without handshake.
- Priority: rst > clear > output handshake > input beat.
- Reset values: state FILL, filled_mask 0, lane registers 0, out_valid 0, out_data 0, err_dup 0, err_range 0. in_ready is 1 after reset (when clear is low).

## Timing
- Input-to-output latency: out_valid rises one cycle after the edge that accepted the final missing lane.
- The word stays on out_data for as long as out_ready is low. There is no timeout.
- Back-to-back words: the handshake edge returns to FILL, so in_ready is high in the following cycle. Minimum period is NUM_DATA + 1 cycles per word.
- Simultaneous out handshake and in_valid in FULL: the input beat is not accepted (in_ready = 0) and must be held by the source.
- err_dup and err_range are registered. They are high for exactly the cycle after the offending edge, and low otherwise.
- rst or clear asserted mid-fill discards all partial lanes. The next accepted beat starts a fresh word.
- out_data and filled_mask are driven directly from registers, with no combinational path from inputs. in_ready depends combinationally only on state and clear.

## Test plan
- In-order fill (NUM_DATA=4, DATA_BW=8): sel 0..3 with lane data 0x11, 0x22, 0x33, 0x44, out_ready=1 → out_valid high one cycle after the sel=3 beat, out_data=0x44332211, and in_ready high on the next cycle.
- Out-of-order fill with backpressure: sel 2, 0, 3, 1 (0xA2, 0xA0, 0xA3, 0xA1), out_ready=0 for 5 cycles → out_data=0xA3A2A1A0 held stable, in_ready=0 throughout, then emitted on out_ready=1.
- Duplicate lane: sel 1=0x05, then sel 1=0x06, then lanes 0, 2, 3 → err_dup pulses once and lane 1 of the emitted word = 0x06.
- Range error (NUM_DATA=3, SEL_WIDTH=2): a beat with sel=3 → err_range pulses, filled_mask is unchanged, and the word completes only after lanes 0–2 are written.
- Mid-fill clear: write lanes 0 and 1, pulse clear, then write all 4 lanes with 0x01..0x04 → filled_mask is 0 after the clear and out_data=0x04030201.
- Reset in FULL: assert rst while out_valid=1 → next cycle out_valid=0, filled_mask=0, out_data=0, in_ready=1.
